// File: rtl/clk_div_ctrl.sv
// Programmable clock divider: TICK/DIV_OUT/CNT track a period of DIV_ACT CLK cycles.
// Latency: run starts on the EN edge; a new ratio applies on the next period boundary.
// Backpressure: CFG_READY drops while a ratio change waits for the period wrap.
//
// Ports:
//   CLK, RST_N        clock, asynchronous active-low reset
//   EN                level-sensitive run request
//   CFG_VALID/CFG_DIV divide-ratio request (legal 2..2^WIDTH-1), taken when CFG_READY=1
//   CFG_ERR           one-cycle pulse after an illegal ratio (0 or 1) was consumed
//   TICK              first cycle of each output period
//   DIV_OUT           divided square wave, high for floor(N/2) cycles of each period
//   BUSY              running (RUN) or finishing the last period (DRAIN)
//   CNT               position within the current period
module clk_div_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             EN,
    input  logic             CFG_VALID,
    input  logic [WIDTH-1:0] CFG_DIV,
    output logic             CFG_READY,
    output logic             CFG_ERR,
    output logic             TICK,
    output logic             DIV_OUT,
    output logic             BUSY,
    output logic [WIDTH-1:0] CNT
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] div_act, div_act_nxt;
    logic [WIDTH-1:0] pend_div, pend_div_nxt;
    logic             pend_vld, pend_vld_nxt;
    logic             cfg_err, cfg_err_nxt;

    logic running;
    logic wrap;
    logic accept;
    logic legal;

    assign running = (state != IDLE);
    // DIV_ACT is always >= 2, so DIV_ACT-1 never underflows.
    assign wrap    = running && (cnt == div_act - WIDTH'(1));
    assign accept  = CFG_VALID && !pend_vld;
    assign legal   = (CFG_DIV >= WIDTH'(2));

    // Next-state and datapath update.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        div_act_nxt  = div_act;
        pend_div_nxt = pend_div;
        pend_vld_nxt = pend_vld;
        cfg_err_nxt  = accept && !legal;

        case (state)
            IDLE: begin
                if (EN) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (!EN) begin
                    state_nxt = wrap ? IDLE : DRAIN;
                end
            end
            DRAIN: begin
                if (EN) begin
                    state_nxt = RUN;
                end else if (wrap) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (running) begin
            cnt_nxt = wrap ? '0 : cnt + WIDTH'(1);
        end else begin
            cnt_nxt = '0;
        end

        // A pending ratio exists only when nothing can be accepted, so the
        // apply and accept paths below never collide. A value accepted on a
        // wrap edge lands in pend_* and waits for the following wrap.
        if (wrap && pend_vld) begin
            div_act_nxt  = pend_div;
            pend_vld_nxt = 1'b0;
        end

        if (accept && legal) begin
            if (running) begin
                pend_div_nxt = CFG_DIV;
                pend_vld_nxt = 1'b1;
            end else begin
                div_act_nxt  = CFG_DIV;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt      <= '0;
            div_act  <= WIDTH'(2);
            pend_div <= '0;
            pend_vld <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            div_act  <= div_act_nxt;
            pend_div <= pend_div_nxt;
            pend_vld <= pend_vld_nxt;
            cfg_err  <= cfg_err_nxt;
        end
    end

    // Outputs decode registered state only.
    assign CFG_READY = !pend_vld;
    assign CFG_ERR   = cfg_err;
    assign BUSY      = running;
    assign CNT       = cnt;
    assign TICK      = running && (cnt == '0);
    assign DIV_OUT   = running && (cnt < (div_act >> 1));

endmodule

// File: tb/tb_clk_div_ctrl.sv
module tb_clk_div_ctrl;

    logic       CLK;
    logic       RST_N;
    logic       EN;
    logic       CFG_VALID;
    logic [7:0] CFG_DIV;
    logic       CFG_READY;
    logic       CFG_ERR;
    logic       TICK;
    logic       DIV_OUT;
    logic       BUSY;
    logic [7:0] CNT;

    int checks;
    int failures;

    clk_div_ctrl #(.WIDTH(8)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .EN        (EN),
        .CFG_VALID (CFG_VALID),
        .CFG_DIV   (CFG_DIV),
        .CFG_READY (CFG_READY),
        .CFG_ERR   (CFG_ERR),
        .TICK      (TICK),
        .DIV_OUT   (DIV_OUT),
        .BUSY      (BUSY),
        .CNT       (CNT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Advance one rising edge and settle 1 ns past it.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST_N     = 1'b0;
        EN        = 1'b0;
        CFG_VALID = 1'b0;
        CFG_DIV   = 8'd0;
        step();
        step();
        RST_N = 1'b1;
    endtask

    // {BUSY,TICK,DIV_OUT,CFG_READY,CFG_ERR,CNT}
    function automatic logic [12:0] obs();
        return {BUSY, TICK, DIV_OUT, CFG_READY, CFG_ERR, CNT};
    endfunction

    task automatic test_reset();
        logic [12:0] exp;
        RST_N = 1'b0; EN = 1'b0; CFG_VALID = 1'b0; CFG_DIV = 8'd0;
        #3;
        exp = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
        checks++;
        if (obs() !== exp) begin
            $display("FAIL reset_state got=%h exp=%h", obs(), exp); failures++;
        end
        step();
        RST_N = 1'b1;
        step();
        checks++;
        if (obs() !== exp) begin
            $display("FAIL reset_idle_no_en got=%h exp=%h", obs(), exp); failures++;
        end
    endtask

    task automatic test_default_div2();
        logic [12:0] exp;
        do_reset();
        EN = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            exp = {1'b1, (i % 2) == 0, (i % 2) == 0, 1'b1, 1'b0, 8'(i % 2)};
            checks++;
            if (obs() !== exp) begin
                $display("FAIL div2 cyc=%0d got=%h exp=%h", i, obs(), exp); failures++;
            end
            step();
        end
    endtask

    task automatic test_div5();
        logic [12:0] exp;
        do_reset();
        CFG_VALID = 1'b1; CFG_DIV = 8'd5;
        step();
        CFG_VALID = 1'b0;
        exp = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
        checks++;
        if (obs() !== exp) begin
            $display("FAIL div5_idle_cfg got=%h exp=%h", obs(), exp); failures++;
        end
        EN = 1'b1;
        step();
        for (int i = 0; i < 15; i++) begin
            exp = {1'b1, (i % 5) == 0, (i % 5) < 2, 1'b1, 1'b0, 8'(i % 5)};
            checks++;
            if (obs() !== exp) begin
                $display("FAIL div5 cyc=%0d got=%h exp=%h", i, obs(), exp); failures++;
            end
            step();
        end
    endtask

    task automatic test_reconfig();
        logic [12:0] exp;
        logic [7:0]  cseq [9] = '{8'd2, 8'd3, 8'd4, 8'd0, 8'd1, 8'd2, 8'd0, 8'd1, 8'd2};
        logic [7:0]  n;
        do_reset();
        CFG_VALID = 1'b1; CFG_DIV = 8'd5;
        step();
        CFG_VALID = 1'b0; EN = 1'b1;
        step();  // CNT=0
        step();  // CNT=1
        CFG_VALID = 1'b1; CFG_DIV = 8'd3;
        step();  // accepted, CNT=2
        CFG_VALID = 1'b0;
        for (int i = 0; i < 9; i++) begin
            n   = (i < 3) ? 8'd5 : 8'd3;
            exp = {1'b1, cseq[i] == 8'd0, cseq[i] < (n >> 1), i >= 3, 1'b0, cseq[i]};
            checks++;
            if (obs() !== exp) begin
                $display("FAIL reconfig cyc=%0d got=%h exp=%h", i, obs(), exp); failures++;
            end
            step();
        end
    endtask

    task automatic test_drain();
        logic [12:0] exp;
        do_reset();
        CFG_VALID = 1'b1; CFG_DIV = 8'd4;
        step();
        CFG_VALID = 1'b0; EN = 1'b1;
        step();  // CNT=0
        step();  // CNT=1
        EN = 1'b0;
        step();
        exp = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2};
        checks++;
        if (obs() !== exp) begin
            $display("FAIL drain_cnt2 got=%h exp=%h", obs(), exp); failures++;
        end
        step();
        exp = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd3};
        checks++;
        if (obs() !== exp) begin
            $display("FAIL drain_cnt3 got=%h exp=%h", obs(), exp); failures++;
        end
        step();
        exp = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
        checks++;
        if (obs() !== exp) begin
            $display("FAIL drain_to_idle got=%h exp=%h", obs(), exp); failures++;
        end
        step();
        checks++;
        if (obs() !== exp) begin
            $display("FAIL drain_stays_idle got=%h exp=%h", obs(), exp); failures++;
        end
        // Second run: re-raise EN while draining.
        EN = 1'b1;
        step();  // CNT=0
        step();  // CNT=1
        EN = 1'b0;
        step();  // DRAIN, CNT=2
        EN = 1'b1;
        step();
        exp = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd3};
        checks++;
        if (obs() !== exp) begin
            $display("FAIL drain_rerun_cnt3 got=%h exp=%h", obs(), exp); failures++;
        end
        step();
        exp = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0};
        checks++;
        if (obs() !== exp) begin
            $display("FAIL drain_rerun_wrap got=%h exp=%h", obs(), exp); failures++;
        end
        step();
        exp = {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1};
        checks++;
        if (obs() !== exp) begin
            $display("FAIL drain_rerun_cnt1 got=%h exp=%h", obs(), exp); failures++;
        end
    endtask

    task automatic test_illegal_and_max();
        logic [12:0] exp;
        int highs;
        int ticks;
        do_reset();
        CFG_VALID = 1'b1; CFG_DIV = 8'd1;
        step();
        CFG_VALID = 1'b0;
        exp = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0};
        checks++;
        if (obs() !== exp) begin
            $display("FAIL cfgerr_pulse got=%h exp=%h", obs(), exp); failures++;
        end
        step();
        exp = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
        checks++;
        if (obs() !== exp) begin
            $display("FAIL cfgerr_clear got=%h exp=%h", obs(), exp); failures++;
        end
        EN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            exp = {1'b1, (i % 2) == 0, (i % 2) == 0, 1'b1, 1'b0, 8'(i % 2)};
            checks++;
            if (obs() !== exp) begin
                $display("FAIL cfgerr_keeps_div2 cyc=%0d got=%h exp=%h", i, obs(), exp); failures++;
            end
        end
        do_reset();
        CFG_VALID = 1'b1; CFG_DIV = 8'd255;
        step();
        CFG_VALID = 1'b0; EN = 1'b1;
        step();
        highs = 0;
        ticks = 0;
        for (int i = 0; i < 255; i++) begin
            checks++;
            if (CNT !== 8'(i)) begin
                $display("FAIL max_cnt cyc=%0d got=%0d exp=%0d", i, CNT, i); failures++;
            end
            if (DIV_OUT === 1'b1) highs++;
            if (TICK === 1'b1) ticks++;
            step();
        end
        checks++;
        if (highs != 127) begin
            $display("FAIL max_high_cycles got=%0d exp=127", highs); failures++;
        end
        checks++;
        if (ticks != 1) begin
            $display("FAIL max_ticks got=%0d exp=1", ticks); failures++;
        end
        exp = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0};
        checks++;
        if (obs() !== exp) begin
            $display("FAIL max_wrap got=%h exp=%h", obs(), exp); failures++;
        end
    endtask

    task automatic test_reset_midperiod();
        logic [12:0] exp;
        do_reset();
        CFG_VALID = 1'b1; CFG_DIV = 8'd6;
        step();
        CFG_VALID = 1'b0; EN = 1'b1;
        step();  // CNT=0
        step();  // CNT=1
        step();  // CNT=2
        CFG_VALID = 1'b1; CFG_DIV = 8'd4;
        step();  // CNT=3, pending 4
        CFG_VALID = 1'b0;
        exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3};
        checks++;
        if (obs() !== exp) begin
            $display("FAIL rst_pre_pending got=%h exp=%h", obs(), exp); failures++;
        end
        #2;
        RST_N = 1'b0;
        #1;
        exp = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
        checks++;
        if (obs() !== exp) begin
            $display("FAIL rst_async got=%h exp=%h", obs(), exp); failures++;
        end
        step();
        RST_N = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            exp = {1'b1, (i % 2) == 0, (i % 2) == 0, 1'b1, 1'b0, 8'(i % 2)};
            checks++;
            if (obs() !== exp) begin
                $display("FAIL rst_post_div2 cyc=%0d got=%h exp=%h", i, obs(), exp); failures++;
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_default_div2();
        test_div5();
        test_reconfig();
        test_drain();
        test_illegal_and_max();
        test_reset_midperiod();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clk_div_ctrl.md
CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, the width of the divide ratio and of the counter.
REQ-002 The block SHALL have the following ports:
  CLK  input  1  sole clock; all state updates on its rising edge.
  RST_N  input  1  asynchronous, active-low reset.
  EN  input  1  run request; level-sensitive.
  CFG_VALID  input  1  divide-ratio update request.
  CFG_DIV  input  WIDTH  requested period N in CLK cycles; legal range 2..2^WIDTH-1.
  CFG_READY  output  1  block can accept a configuration this cycle.
  CFG_ERR  output  1  one-cycle pulse: the last accepted configuration was illegal.
  TICK  output  1  one-cycle pulse on the first cycle of each output period.
  DIV_OUT  output  1  divided square wave.
  BUSY  output  1  high while the block is in RUN or DRAIN.
  CNT  output  WIDTH  current position within the period.
REQ-003 All outputs SHALL be driven only by registered state, with no combinational path from any input.

Function
REQ-004 The FSM SHALL have three states: IDLE (stopped), RUN (counting, EN high) and DRAIN (counting, finishing the current period after EN falls).
REQ-005 IDLE->RUN SHALL occur on the edge where EN=1; after that edge CNT=0.
REQ-006 In RUN or DRAIN, each edge SHALL set CNT to 0 if CNT==DIV_ACT-1 (the wrap edge), otherwise to CNT+1; DIV_ACT is the active period register.
REQ-007 RUN->DRAIN SHALL occur on a non-wrap edge where EN=0; on a wrap edge with EN=0 the FSM SHALL go directly to IDLE.
REQ-008 DRAIN->IDLE SHALL occur on the wrap edge; DRAIN->RUN SHALL occur on any edge where EN=1, with counting undisturbed.
REQ-009 In IDLE, CNT SHALL be 0, TICK SHALL be 0 and DIV_OUT SHALL be 0.
REQ-010 TICK SHALL be 1 exactly when the state is RUN or DRAIN and CNT==0.
REQ-011 DIV_OUT SHALL be 1 exactly when the state is RUN or DRAIN and CNT < floor(DIV_ACT/2); for example N=2 gives 1 high and 1 low cycle, and N=5 gives 2 high and 3 low.
REQ-012 BUSY SHALL be 1 in RUN and in DRAIN.
REQ-013 A configuration SHALL be accepted on an edge where CFG_VALID=1 and CFG_READY=1.
REQ-014 CFG_READY SHALL be 1 unless a pending configuration is held.
REQ-015 An accepted legal value in IDLE SHALL load DIV_ACT on the acceptance edge, and no pending configuration SHALL be held.
REQ-016 An accepted legal value in RUN or DRAIN SHALL be stored as pending, dropping CFG_READY.
REQ-017 A pending value SHALL load DIV_ACT on the next wrap edge, and CFG_READY SHALL return to 1 after that edge.
REQ-018 A configuration accepted on a wrap edge SHALL NOT apply at that wrap; it SHALL apply at the following wrap.
REQ-019 A pending value SHALL also be applied if the FSM reaches IDLE, because IDLE is only entered on a wrap edge.
REQ-020 An accepted CFG_DIV of 0 or 1 SHALL be consumed without changing DIV_ACT or the pending state, and CFG_ERR SHALL be 1 for the following cycle only.
REQ-021 The new period SHALL start at CNT=0 with the new DIV_ACT; no truncated or stretched period SHALL ever be produced.
REQ-022 CNT SHALL never reach or exceed DIV_ACT; all comparisons SHALL be unsigned at WIDTH bits.
REQ-023 At N=2^WIDTH-1, CNT SHALL wrap from 2^WIDTH-2 to 0.

Reset
REQ-024 While RST_N=0, regardless of CLK, the state SHALL be IDLE, CNT=0, DIV_ACT=2, pending cleared, CFG_READY=1, CFG_ERR=0, TICK=0, DIV_OUT=0 and BUSY=0.
REQ-025 Reset asserted mid-period SHALL abort the period immediately and discard any pending configuration.
REQ-026 After RST_N rises, the first edge with EN=1 SHALL behave as REQ-005.

Verification
REQ-027 Scenario 1: reset, EN=1 held, default N=2 -> TICK every 2nd cycle and DIV_OUT toggles 1,0,1,0 with BUSY=1.
REQ-028 Scenario 2: in IDLE, configure N=5, then EN=1 -> CNT sequence 0..4 repeating, TICK once per 5 cycles, DIV_OUT high 2 cycles and low 3.
REQ-029 Scenario 3: running N=5, apply CFG_DIV=3 at CNT=1 -> CFG_READY=0 until the wrap, then periods of 3 cycles; the period in progress is a full 5 cycles.
REQ-030 Scenario 4: running N=4, drop EN at CNT=1 -> DRAIN for CNT 2 and 3, then IDLE with BUSY=0; a second run re-raising EN at CNT=2 -> stays BUSY with an uninterrupted count.
REQ-031 Scenario 5: CFG_DIV=1 accepted -> one-cycle CFG_ERR pulse and the period is unchanged; CFG_DIV=255 with WIDTH=8 -> a 255-cycle period with DIV_OUT high for 127 cycles.
REQ-032 Scenario 6: RST_N pulsed low at CNT=3 of N=6 with a pending value of 4 -> all outputs at reset values at once, and after release N=2 (the pending value is lost).
